// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: control codes, muldiv op codes
// and sequencer state encodings.
package alu_defs;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_SUB_AB = 4'b0010;
    localparam logic [3:0] ALU_SUB_BA = 4'b0011;
    localparam logic [3:0] ALU_ADD    = 4'b0100;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that
// borrows the core ALU for one add/sub step per cycle.
module alu_muldiv_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_co
);

    localparam int CW = $clog2(WIDTH);

    state_e           state;
    state_e           state_d;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] sh;
    logic             take;
    logic             last;
    logic             iter;

    assign sh   = {hi[WIDTH-2:0], lo[WIDTH-1]};
    assign take = hi[WIDTH-1] | alu_co;
    assign last = (count == CW'(WIDTH - 1));
    assign iter = (state == S_MUL) || (state == S_DIV);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, ALU bus drive and per-iteration hi/lo update.
    always_comb begin
        state_d     = state;
        alu_control = ALU_AND;
        alu_a       = '0;
        alu_b       = '0;
        hi_d        = hi;
        lo_d        = lo;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                alu_control  = ALU_ADD;
                alu_a        = hi;
                alu_b        = lo[0] ? opnd : '0;
                {hi_d, lo_d} = {alu_co, alu_out, lo[WIDTH-1:1]};
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                alu_control = ALU_SUB_AB;
                alu_a       = sh;
                alu_b       = opnd;
                hi_d        = take ? alu_out : sh;
                lo_d        = {lo[WIDTH-2:0], take};
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch on accept, iteration registers and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            count  <= '0;
            op_q   <= '0;
            result <= '0;
        end else if (state == S_IDLE && start) begin
            op_q  <= op;
            count <= '0;
            hi    <= '0;
            lo    <= op[1] ? src_a : src_b;
            opnd  <= op[1] ? src_b : src_a;
        end else if (iter) begin
            hi    <= hi_d;
            lo    <= lo_d;
            count <= count + 1'b1;
            if (last) begin
                result <= op_q[0] ? hi_d : lo_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with an ALU
// model on the shared bus and a plain-arithmetic reference.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   alu_control;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic         alu_co;

    int errors;
    int checks;
    int done_cnt;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .busy(busy),
        .done(done),
        .result(result),
        .alu_control(alu_control),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_out(alu_out),
        .alu_co(alu_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core ALU stand-in: AND, A-B (CO=1 no borrow), ADD.
    always_comb begin
        logic [W:0] t;
        t = '0;
        case (alu_control)
            4'b0010: t = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
            4'b0100: t = {1'b0, alu_a} + {1'b0, alu_b};
            default: t = {1'b0, alu_a & alu_b};
        endcase
        alu_out = t[W-1:0];
        alu_co  = t[W];
    end

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    function automatic logic [W-1:0] ref_model(
        input logic [1:0] o, input logic [W-1:0] a,
        input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00: return p[W-1:0];
            2'b01: return p[2*W-1:W];
            2'b10: return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Raise start after an edge, wait for done; lat in edges.
    task automatic run_op(input logic [1:0] o,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] o,
                            input logic [W-1:0] a,
                            input logic [W-1:0] b);
        int lat;
        int d0;
        logic [W-1:0] exp;
        exp = ref_model(o, a, b);
        d0 = done_cnt;
        run_op(o, a, b, lat);
        checks++;
        if (lat !== W + 1) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, W + 1);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result got %h want %h", name, result, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s pulse done=%b busy=%b pulses=%0d want 0 0 1",
                     name, done, busy, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, alu_control, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b res=%h ctl=%h a=%h b=%h want 0",
                     busy, done, result, alu_control, alu_a, alu_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_op("mul7x6", 2'b00, 32'd7, 32'd6);
        check_op("mulhu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_op("divu100_7", 2'b10, 32'd100, 32'd7);
        check_op("remu100_7", 2'b11, 32'd100, 32'd7);
        check_op("divu_by0", 2'b10, 32'h12345678, 32'd0);
        check_op("remu_by0", 2'b11, 32'h12345678, 32'd0);
        check_op("divu_msb", 2'b10, 32'hFFFFFFFF, 32'h80000000);
        check_op("remu_msb", 2'b11, 32'hFFFFFFFF, 32'h80000000);
        checks++;
        if (ref_model(2'b00, 32'd7, 32'd6) !== result && 1'b0) errors++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = W'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            check_op($sformatf("rand%0d", i), o, a, b);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int d0;
        logic [W-1:0] exp;
        exp = ref_model(2'b10, 32'd1000, 32'd33);
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd33;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (n == 5) begin
                start = 1'b1; op = 2'b00;
                src_a = 32'hDEAD; src_b = 32'hBEEF;
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b1; op = 2'b01; src_a = 32'h55; src_b = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (lat !== W + 1 || result !== exp) begin
            errors++;
            $display("FAIL busy_ignore lat=%0d res=%h want %0d %h",
                     lat, result, W + 1, exp);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done_cnt - d0 != 1 || result !== exp) begin
            errors++;
            $display("FAIL busy_ignore_after busy=%b pulses=%0d res=%h want 0 1 %h",
                     busy, done_cnt - d0, result, exp);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int gap;
        int seen;
        logic [W-1:0] exp;
        exp = ref_model(2'b00, 32'd12345, 32'd678);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; src_a = 32'd12345; src_b = 32'd678;
        t0 = 0; gap = -1; seen = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                seen++;
                if (seen == 1) t0 = n;
                if (seen == 2) begin
                    gap = n - t0;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (gap !== W + 2) begin
            errors++;
            $display("FAIL back_to_back period got %0d want %0d", gap, W + 2);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL back_to_back result got %h want %h", result, exp);
        end
        repeat (W + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int d0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; src_a = 32'h9999; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b res=%h want 0 0 0",
                     busy, done, result);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_abort pulses=%0d busy=%b want 0 0",
                     done_cnt - d0, busy);
        end
        check_op("after_reset", 2'b11, 32'hCAFEF00D, 32'd1234);
    endtask

    initial begin
        errors = 0; checks = 0; done_cnt = 0;
        start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
